// File: rtl/qspi_rx_capture_ctrl_if.sv
// Word handshake between the QSPI RX capture controller and the AHB read FIFO.
// Master drives the captured word; slave returns word_ready.
interface qspi_rx_capture_ctrl_if;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
  logic        word_last;

  modport master (
    output word_valid, word_data, word_bytes, word_last,
    input  word_ready
  );

  modport slave (
    input  word_valid, word_data, word_bytes, word_last,
    output word_ready
  );
endinterface

// File: rtl/qspi_rx_capture_ctrl.sv
// QSPI read data-phase sequencer: gates sample pulses, packs 32-bit words.
// Optional QSPI_RX_BYTE_SWAP_EN byte-reverses the valid bytes of each word.
module qspi_rx_capture_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len_bytes,
  input  logic             use_1_io_lines_in,
  input  logic             use_2_io_lines_in,
  input  logic             use_4_io_lines_in,
  input  logic             sclk_sample_pulse,
  input  logic [31:0]      sample_data_in,
  output logic             sample_en,
  output logic             use_1_io_lines_out,
  output logic             use_2_io_lines_out,
  output logic             use_4_io_lines_out,
  output logic             sclk_hold,
  output logic             busy,
  output logic             done,
  output logic             err_mode,
  output logic             overrun,
  qspi_rx_capture_ctrl_if.master wif
);

  localparam int RW = LEN_W + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_PUSH,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    mode_q, mode_d, mode_sel;
  logic [RW-1:0] rem_q, rem_d, rem_nxt;
  logic [5:0]    wbits_q, wbits_d, wbits_nxt;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;
  logic [31:0]   data_fmt;
  logic          push;

  always_comb begin
    mode_sel = 3'b000;
    if (use_1_io_lines_in)
      mode_sel = 3'b001;
    else if (use_2_io_lines_in)
      mode_sel = 3'b010;
    else if (use_4_io_lines_in)
      mode_sel = 3'b100;
  end

  // One-hot mode value is numerically the bit count per sample.
  assign wbits_nxt = wbits_q + {3'b000, mode_q};
  assign rem_nxt   = rem_q - {{LEN_W{1'b0}}, mode_q};

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    wbits_d   = wbits_q;
    err_d     = 1'b0;
    ovr_d     = ovr_q;
    sample_en = 1'b0;
    sclk_hold = 1'b0;
    push      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ovr_d = 1'b0;
          if (mode_sel == 3'b000) begin
            err_d = 1'b1;
          end else begin
            mode_d  = mode_sel;
            rem_d   = {len_bytes, 3'b000};
            wbits_d = '0;
            state_d = (len_bytes == '0) ? S_DONE : S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        sample_en = sclk_sample_pulse & ~abort;
        if (sclk_sample_pulse) begin
          wbits_d = wbits_nxt;
          rem_d   = rem_nxt;
          if (wbits_nxt == 6'd32 || rem_nxt == '0)
            state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        sclk_hold = 1'b1;
        push      = 1'b1;
        if (sclk_sample_pulse)
          ovr_d = 1'b1;
        if (wif.word_ready) begin
          wbits_d = '0;
          state_d = (rem_q == '0) ? S_DONE : S_CAPTURE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
      mode_d  = mode_q;
      rem_d   = '0;
      wbits_d = '0;
      err_d   = 1'b0;
      ovr_d   = ovr_q;
    end
  end

`ifdef QSPI_RX_BYTE_SWAP_EN
  // Partial words: only the valid low bytes are reversed, upper bytes zero.
  always_comb begin
    data_fmt = 32'h0;
    unique case (wbits_q[5:3])
      3'd1:    data_fmt = {24'h0, sample_data_in[7:0]};
      3'd2:    data_fmt = {16'h0, sample_data_in[7:0],
                           sample_data_in[15:8]};
      3'd3:    data_fmt = {8'h0, sample_data_in[7:0],
                           sample_data_in[15:8],
                           sample_data_in[23:16]};
      default: data_fmt = {sample_data_in[7:0],
                           sample_data_in[15:8],
                           sample_data_in[23:16],
                           sample_data_in[31:24]};
    endcase
  end
`else
  assign data_fmt = sample_data_in;
`endif

  assign wif.word_valid = push;
  assign wif.word_data  = push ? data_fmt : 32'h0;
  assign wif.word_bytes = push ? wbits_q[5:3] : 3'd0;
  assign wif.word_last  = push & (rem_q == '0);

  assign use_1_io_lines_out = mode_q[0];
  assign use_2_io_lines_out = mode_q[1];
  assign use_4_io_lines_out = mode_q[2];
  assign busy               = (state_q != S_IDLE);
  assign err_mode           = err_q;
  assign overrun            = ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 3'b000;
      rem_q   <= '0;
      wbits_q <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      wbits_q <= wbits_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule
